// File: rtl/pwm_multi.sv
// rtl/pwm_multi.sv - multi-channel audio-to-PWM converter with shared frame counter.
// Optional peak-hold/decay colour envelope under `PWM_MULTI_DECAY_EN`.
module pwm_multi #(
  parameter int NUM_CH     = 2,
  parameter int DATA_W     = 48,
  parameter int RANGE_H    = 28,
  parameter int NUM_BITS   = 11,
  parameter int DECAY_STEP = 4
) (
  input  logic                       clk_pwm,
  input  logic                       nreset,
  input  logic [NUM_CH*DATA_W-1:0]   data,
  input  logic                       data_ready,
  output logic [NUM_CH-1:0]          out,
  output logic [8*NUM_CH-1:0]        color,
  output logic                       frame
);

  localparam int LO = RANGE_H - NUM_BITS + 1;

  if (RANGE_H > DATA_W - 2 || LO < 0 || NUM_BITS < 6 ||
      DECAY_STEP < 0 || DECAY_STEP >= (1 << NUM_BITS)) begin : g_param_check
    $error("pwm_multi: illegal parameter combination");
  end

  logic [2:0]                       rdy_q;
  logic                             rdy_r_q;
  logic [NUM_BITS-1:0]              counter_q, counter_d;
  logic [NUM_CH-1:0][NUM_BITS-1:0]  level_q, level_d, lvl_next;
  logic [NUM_CH-1:0]                out_q, out_d;
  logic                             frame_q;

  // Shifting the whole magnitude down keeps every bit in use: bits above the
  // slice land above NUM_BITS-1 and drive saturation.
  always_comb begin
    logic [DATA_W-1:0] s;
    logic [DATA_W-1:0] mag;
    logic [DATA_W-1:0] shifted;
    s        = '0;
    mag      = '0;
    shifted  = '0;
    lvl_next = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      s       = data[k*DATA_W +: DATA_W];
      mag     = s[DATA_W-1] ? (~s + {{(DATA_W-1){1'b0}}, 1'b1}) : s;
      shifted = mag >> LO;
      lvl_next[k] = (|shifted[DATA_W-1:NUM_BITS]) ? '1 : shifted[NUM_BITS-1:0];
    end
  end

  always_comb begin
    counter_d = rdy_r_q ? '0 : counter_q + 1'b1;
    level_d   = rdy_r_q ? lvl_next : level_q;
    for (int k = 0; k < NUM_CH; k++) begin
      out_d[k] = level_q[k] > counter_q;
    end
  end

  always_ff @(posedge clk_pwm or negedge nreset) begin
    if (!nreset) begin
      rdy_q     <= '0;
      rdy_r_q   <= 1'b0;
      counter_q <= '0;
      level_q   <= '0;
      out_q     <= '0;
      frame_q   <= 1'b0;
    end else begin
      rdy_q     <= {rdy_q[1:0], data_ready};
      rdy_r_q   <= (rdy_q[2:1] == 2'b01);
      counter_q <= counter_d;
      level_q   <= level_d;
      out_q     <= out_d;
      frame_q   <= rdy_r_q;
    end
  end

`ifdef PWM_MULTI_DECAY_EN
  localparam logic [NUM_BITS-1:0] STEP = NUM_BITS'(DECAY_STEP);

  logic [NUM_CH-1:0][NUM_BITS-1:0] env_q, env_d;

  always_comb begin
    logic [NUM_BITS-1:0] dec;
    dec   = '0;
    env_d = env_q;
    if (rdy_r_q) begin
      for (int k = 0; k < NUM_CH; k++) begin
        dec      = (env_q[k] >= STEP) ? env_q[k] - STEP : '0;
        env_d[k] = (lvl_next[k] > dec) ? lvl_next[k] : dec;
      end
    end
  end

  always_ff @(posedge clk_pwm or negedge nreset) begin
    if (!nreset) begin
      env_q <= '0;
    end else begin
      env_q <= env_d;
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_color
    assign color[8*k +: 8] = {2'b00, env_q[k][NUM_BITS-1 -: 6]};
  end
`else
  // Without the envelope the colour simply tracks the loaded level.
  for (genvar k = 0; k < NUM_CH; k++) begin : g_color
    assign color[8*k +: 8] = {2'b00, level_q[k][NUM_BITS-1 -: 6]};
  end
`endif

  assign out   = out_q;
  assign frame = frame_q;

endmodule

// File: tb/tb_pwm_multi.sv
// tb/tb_pwm_multi.sv - randomized self-checking bench for pwm_multi against a frame-level model.
module tb_pwm_multi;

  localparam int NUM_CH   = 2;
  localparam int DATA_W   = 48;
  localparam int NUM_BITS = 11;
  localparam int PERIOD   = 1 << NUM_BITS;

  logic                      clk_pwm = 1'b0;
  logic                      nreset = 1'b0;
  logic [NUM_CH*DATA_W-1:0]  data = '0;
  logic                      data_ready = 1'b0;
  logic [NUM_CH-1:0]         out;
  logic [8*NUM_CH-1:0]       color;
  logic                      frame;

  pwm_multi dut (
    .clk_pwm    (clk_pwm),
    .nreset     (nreset),
    .data       (data),
    .data_ready (data_ready),
    .out        (out),
    .color      (color),
    .frame      (frame)
  );

  always #5 clk_pwm = ~clk_pwm;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input longint unsigned got, input longint unsigned exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Frame-level model: edge index n, time of last load, levels and envelopes.
  int  n;
  int  frm_edge;
  bit  have_frm;
  int  pend[$];
  bit  prev_dr;
  int  m_lvl[NUM_CH];
  int  m_env[NUM_CH];
  bit  m_frame;
  bit  [NUM_CH-1:0] m_out;

  function automatic int level_of(input logic [DATA_W-1:0] v);
    longint s;
    longint mag;
    s   = $signed(v);
    mag = (s < 0) ? -s : s;
    if (mag >= (64'sd1 << 29)) return PERIOD - 1;
    return int'(mag >>> 18);
  endfunction

  task automatic model_reset();
    n = 0; have_frm = 0; frm_edge = 0; pend.delete(); prev_dr = 0;
    m_frame = 0; m_out = '0;
    for (int k = 0; k < NUM_CH; k++) begin m_lvl[k] = 0; m_env[k] = 0; end
  endtask

  task automatic model_step();
    int l;
    int d;
    if (!nreset) return;
    n++;
    for (int k = 0; k < NUM_CH; k++)
      m_out[k] = have_frm ? (m_lvl[k] > ((n - 1 - frm_edge) % PERIOD)) : 1'b0;
    m_frame = 0;
    if (pend.size() > 0 && pend[0] == n) begin
      void'(pend.pop_front());
      m_frame = 1; frm_edge = n; have_frm = 1;
      for (int k = 0; k < NUM_CH; k++) begin
        l = level_of(data[k*DATA_W +: DATA_W]);
        m_lvl[k] = l;
`ifdef PWM_MULTI_DECAY_EN
        d = m_env[k] - 4;
        if (d < 0) d = 0;
        m_env[k] = (l > d) ? l : d;
`else
        d = 0;
        m_env[k] = l + d;
`endif
      end
    end
    if (data_ready && !prev_dr) pend.push_back(n + 3);
    prev_dr = data_ready;
  endtask

  function automatic logic [8*NUM_CH-1:0] exp_color();
    logic [8*NUM_CH-1:0] c;
    c = '0;
    for (int k = 0; k < NUM_CH; k++) c[8*k +: 8] = 8'(m_env[k] / 32);
    return c;
  endfunction

  task automatic tick();
    @(posedge clk_pwm);
    model_step();
    @(negedge clk_pwm);
    check("out", out, m_out);
    check("frame", frame, m_frame);
    check("color", color, exp_color());
  endtask

  task automatic set_ch(input int k, input longint v);
    logic [63:0] w;
    w = v;
    data[k*DATA_W +: DATA_W] = w[DATA_W-1:0];
  endtask

  function automatic longint rand_sample();
    logic [63:0] r;
    r = {$urandom, $urandom};
    case ($urandom_range(0, 3))
      0: r = r & ((64'd1 << 29) - 1);
      1: r = r & ((64'd1 << 31) - 1);
      2: r = r & ((64'd1 << 47) - 1);
      default: r = 64'h0000_8000_0000_0000;
    endcase
    if ($urandom_range(0, 1) == 1) r = -r;
    return longint'(r);
  endfunction

  // Raise the strobe, then wait (bounded) for the frame and count one full PWM period.
  task automatic frame_then_count(input string tag, input int e0, input int e1);
    int seen;
    int h0;
    int h1;
    seen = 0; h0 = 0; h1 = 0;
    data_ready = 1'b1;
    repeat (3) tick();
    data_ready = 1'b0;
    for (int i = 0; i < 20 && seen == 0; i++) begin tick(); seen = frame; end
    check({tag, "_frame_seen"}, seen, 1);
    for (int i = 0; i < PERIOD; i++) begin tick(); h0 += out[0]; h1 += out[1]; end
    check({tag, "_high_ch0"}, h0, e0);
    check({tag, "_high_ch1"}, h1, e1);
  endtask

  task automatic wait_frame_latency(input string tag, input int exp_lat);
    int lat;
    lat = 0;
    for (int i = 1; i <= 12 && lat == 0; i++) begin
      tick();
      if (i == 2) data_ready = 1'b0;
      if (frame) lat = i;
    end
    check(tag, lat, exp_lat);
  endtask

  initial begin
    int nf;
    int f1;
    int f2;
    logic [7:0] dec_exp [4];
    model_reset();
    repeat (3) tick();
    check("rst_out", out, 0);
    check("rst_color", color, 0);
    check("rst_frame", frame, 0);
    nreset = 1'b1;
    repeat (4) tick();

    set_ch(0, longint'(256) << 18);
    set_ch(1, -(longint'(512) << 18));
    frame_then_count("duty", 256, 512);

    set_ch(0, longint'(1) << 30);
    set_ch(1, longint'(64'hFFFF_8000_0000_0000));
    frame_then_count("sat", PERIOD - 1, PERIOD - 1);

    set_ch(0, 1000 << 18);
    set_ch(1, 5 << 18);
    nf = 0;
    data_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin tick(); nf += frame; end
    data_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin tick(); nf += frame; end
    check("held_high_frames", nf, 1);

    f1 = 0; f2 = 0; nf = 0;
    for (int i = 1; i <= 40; i++) begin
      data_ready = ((i >= 1 && i <= 4) || (i >= 11 && i <= 14));
      tick();
      if (frame) begin
        nf++;
        if (f1 == 0) f1 = i; else f2 = i;
      end
    end
    data_ready = 1'b0;
    check("two_edge_frames", nf, 2);
    check("two_edge_first_lat", f1, 4);
    check("two_edge_spacing", f2 - f1, 10);

    for (int r = 0; r < 30; r++) begin
      for (int k = 0; k < NUM_CH; k++) set_ch(k, rand_sample());
      data_ready = 1'b1;
      repeat ($urandom_range(2, 8)) tick();
      data_ready = 1'b0;
      repeat ($urandom_range(2, 2500)) tick();
      if (r == 15) begin
        #1 nreset = 1'b0;
        model_reset();
        #1;
        check("midrst_out", out, 0);
        check("midrst_color", color, 0);
        check("midrst_frame", frame, 0);
        data_ready = 1'b1;
        @(negedge clk_pwm);
        nreset = 1'b1;
        wait_frame_latency("midrst_frame_lat", 4);
        data_ready = 1'b0;
        repeat (20) tick();
      end
    end

`ifdef PWM_MULTI_DECAY_EN
    dec_exp = '{8'd63, 8'd63, 8'd63, 8'd63};
`else
    dec_exp = '{8'd63, 8'd0, 8'd0, 8'd0};
`endif
    for (int f = 0; f < 4; f++) begin
      set_ch(0, (f == 0) ? (longint'(1) << 30) : 0);
      set_ch(1, (f == 0) ? -(longint'(1) << 30) : 0);
      data_ready = 1'b1;
      wait_frame_latency("decay_frame_lat", 4);
      check("decay_color_ch0", color[7:0], dec_exp[f]);
      check("decay_color_ch1", color[15:8], dec_exp[f]);
      repeat (10) tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pwm_multi.md
# pwm_multi

Multi-channel successor to the single-channel audio-to-PWM converter in the light-music path. It takes NUM_CH signed sample words from the slow audio/DSP domain and synchronises their shared `data_ready` strobe into `clk_pwm`. For each channel it rectifies and saturates the sample into an NUM_BITS-bit duty level, then drives one PWM output per channel from a common frame counter. Per-channel 8-bit colour levels for the LED driver come from an optional peak-hold/decay envelope.

## Interface
- `NUM_CH`, 2: number of channels.
- `DATA_W`, 48: width of each signed sample.
- `RANGE_H`, 28: MSB index of the magnitude slice; requires RANGE_H ≤ DATA_W-2 and RANGE_H ≥ NUM_BITS-1.
- `NUM_BITS`, 11: duty level / counter width; requires NUM_BITS ≥ 6.
- `DECAY_STEP`, 4: envelope decrement per frame (used only with the macro).

Ports:
- `clk_pwm`  in  1: single clock.
- `nreset`  in  1: asynchronous, active-low reset.
- `data`  in  NUM_CH*DATA_W: packed signed samples; channel k is `data[k*DATA_W +: DATA_W]`.
- `data_ready`  in  1: sample-valid level from another clock domain; a rising edge marks a new frame.
- `out`  out  NUM_CH: registered PWM outputs; bit k is channel k.
- `color`  out  8*NUM_CH: channel k is `{2'b00, env_k[NUM_BITS-1 -: 6]}`.
- `frame`  out  1: registered one-cycle pulse, high in the cycle the new levels are loaded.

## Operation
- Synchroniser:
  - 3-bit shift `rdy <= {rdy[1:0], data_ready}`.
  - `rdy_r <= (rdy[2:1] == 2'b01)` gives one pulse per rising edge. A level held high produces no further pulses.
- Rectify, per channel: `mag = (s < 0) ? -s : s`, computed DATA_W bits unsigned. The most negative input gives 2^(DATA_W-1) and saturates.
- Slice and saturate:
  - `lvl_next = mag[RANGE_H : RANGE_H-NUM_BITS+1]`.
  - If any bit of mag above RANGE_H is set, `lvl_next` is all ones.
- On `rdy_r`, for all channels in the same cycle:
  - `level_k <= lvl_next_k`.
  - `counter <= 0`.
  - `frame <= 1`.
- Otherwise `counter <= counter + 1`, wrapping modulo 2^NUM_BITS; `frame <= 0`.
- PWM output: `out[k] <= (level_k > counter)`.
  - level 0 gives constant low.
  - level all-ones gives high for 2^NUM_BITS-1 of every 2^NUM_BITS cycles.
- If frames arrive slower than 2^NUM_BITS cycles, the counter wraps and the waveform repeats with the same level. If frames arrive faster, the period is truncated at each frame.

## Timing
- Reset values: `rdy`, `rdy_r`, `counter`, all `level_k`, all `env_k`, `out`, and `frame` are 0; `color` is 0.
- Latency from the first `clk_pwm` edge sampling `data_ready` high:
  - edge 3: `rdy_r` high.
  - edge 4: `level`/`env` loaded, `counter` = 0, `frame` = 1.
  - edge 5: `out` reflects the new level.
- Input constraints:
  - `data_ready` must be high ≥ 2 and low ≥ 2 `clk_pwm` cycles.
  - `data` must be stable from the `data_ready` rise until 4 cycles after it.
- Reset asserted mid-frame clears all state immediately. The first frame after release needs a fresh rising edge; a `data_ready` already high at release counts as an edge.

## Configuration
- Macro: `PWM_MULTI_DECAY_EN`.
- Defined: on each `rdy_r`, `env_k <= max(lvl_next_k, sat0(env_k - DECAY_STEP))`. The subtraction saturates at 0, giving peak-hold with linear decay per frame.
- Undefined: `env_k <= lvl_next_k` (colour tracks level), and `DECAY_STEP` is ignored.
- `out` behaviour is identical either way.

## Test plan
- Reset check: assert `nreset` mid-run → `out` = 0, `color` = 0, `frame` = 0; the next `data_ready` edge gives `frame` exactly 4 edges later.
- Duty check: NUM_BITS=11, ch0 sample = 256<<18, ch1 = -(512<<18) → over 2048 cycles ch0 high 256, ch1 high 512.
- Saturation check: ch0 = 2^30 → level 2047, high 2047/2048. ch1 = most-negative 48-bit value → level 2047.
- Strobe handling: `data_ready` held high 100 cycles → exactly one `frame` pulse. Two edges 10 cycles apart → `counter` restarts at each and `out` updates 5 edges after each rise.
- Decay envelope: with `PWM_MULTI_DECAY_EN`, DECAY_STEP=4, frames of 2047 then 0,0,0 → `env` 2047, 2043, 2039, 2035; `color` 63, 63, 63, 63. Without the macro, `color` goes 63, 0, 0, 0.
